// File: rtl/wbgpio_master.sv
// wbgpio_master
// -----------------------------------------------------------------------------
// Single-outstanding-transaction Wishbone (pipelined) bus initiator. Each
// command taken from the valid/ready command stream becomes one bus read or
// write. Exactly one response is returned per command. Stall, ack and err are
// handled here, and an optional bus timeout can end a transaction, so upstream
// logic never sees raw Wishbone timing.
//
// Optional feature macro: WBGPIO_MASTER_TIMEOUT_EN
//   defined     : a cycle counter aborts a transaction after TIMEOUT cycles
//                 spent in REQ/WAIT. The response then has err=1, timeout=1.
//   not defined : no counter is built, the bus wait is unbounded, and
//                 o_rsp_timeout is tied 0.
//
// Parameters
//   AW       Wishbone word-address width
//   TIMEOUT  cycles from strobe issue to forced abort (timeout build only)
//
// Ports
//   i_clk, i_reset_n                    clock; asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready           command handshake
//   i_cmd_we/addr/data/sel              command payload
//   o_wb_cyc/stb/we/addr/data/sel       Wishbone master outputs
//   i_wb_stall/ack/err/data             Wishbone slave responses
//   o_rsp_valid / i_rsp_ready           response handshake
//   o_rsp_data/err/timeout              response payload
//   o_dbg_state                         current FSM state (IDLE=0, REQ=1,
//                                       WAIT=2, RSP=3)
//
// Handshake rule (both streams): a transfer occurs on a rising edge where
// valid and ready are both high. The source holds valid and the payload
// stable until that edge. o_cmd_ready and o_rsp_valid are functions of the
// state register only.
// -----------------------------------------------------------------------------
module wbgpio_master #(
  parameter int AW      = 30,
  parameter int TIMEOUT = 1023
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [31:0]   i_cmd_data,
  input  logic [3:0]    i_cmd_sel,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [31:0]   o_rsp_data,
  output logic          o_rsp_err,
  output logic          o_rsp_timeout,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_take;     // command handshake this cycle
  logic        rsp_load;     // transaction ends this cycle; capture response
  logic [31:0] rsp_data_d;
  logic        rsp_err_d;
  logic        rsp_to_d;
  logic        timeout_hit;
  logic        bus_resp;     // slave response that actually ends the cycle
  logic [31:0] bus_rdata;

  // Read data is returned only for a clean ack on a read. err dominates ack.
  assign bus_rdata = (!o_wb_we && i_wb_ack && !i_wb_err) ? i_wb_data : 32'd0;

`ifdef WBGPIO_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q;

  // The counter is cleared when a command is taken. It counts every cycle in
  // REQ/WAIT. Hitting the limit aborts, unless a response lands in the same
  // cycle (the response wins).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      to_cnt_q <= '0;
    end else if (cmd_take) begin
      to_cnt_q <= '0;
    end else if ((state_q == S_REQ || state_q == S_WAIT) && !timeout_hit) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (to_cnt_q == CW'(TIMEOUT));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state and capture strobes
  always_comb begin
    state_d    = state_q;
    cmd_take   = 1'b0;
    rsp_load   = 1'b0;
    rsp_data_d = 32'd0;
    rsp_err_d  = 1'b0;
    rsp_to_d   = 1'b0;
    bus_resp   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          cmd_take = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // A response can only count once the strobe has been accepted.
        bus_resp = !i_wb_stall && (i_wb_ack || i_wb_err);
        if (bus_resp) begin
          rsp_load   = 1'b1;
          rsp_data_d = bus_rdata;
          rsp_err_d  = i_wb_err;
          state_d    = S_RSP;
        end else if (timeout_hit) begin
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
          rsp_to_d  = 1'b1;
          state_d   = S_RSP;
        end else if (!i_wb_stall) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        bus_resp = i_wb_ack || i_wb_err;
        if (bus_resp) begin
          rsp_load   = 1'b1;
          rsp_data_d = bus_rdata;
          rsp_err_d  = i_wb_err;
          state_d    = S_RSP;
        end else if (timeout_hit) begin
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
          rsp_to_d  = 1'b1;
          state_d   = S_RSP;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus request fields: loaded once per command and held through stalls.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= 32'd0;
      o_wb_sel  <= 4'd0;
    end else if (cmd_take) begin
      o_wb_we   <= i_cmd_we;
      o_wb_addr <= i_cmd_addr;
      o_wb_data <= i_cmd_data;
      o_wb_sel  <= i_cmd_sel;
    end
  end

  // Response fields: captured as the bus transaction ends and held in RSP.
  logic rsp_to_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rsp_data <= 32'd0;
      o_rsp_err  <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else if (rsp_load) begin
      o_rsp_data <= rsp_data_d;
      o_rsp_err  <= rsp_err_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

`ifdef WBGPIO_MASTER_TIMEOUT_EN
  assign o_rsp_timeout = rsp_to_q;
`else
  logic unused_rsp_to;
  assign unused_rsp_to = rsp_to_q;
  assign o_rsp_timeout = 1'b0;
`endif

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_wb_cyc    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign o_wb_stb    = (state_q == S_REQ);
  assign o_rsp_valid = (state_q == S_RSP);
  assign o_dbg_state = state_q;

endmodule
